// File: rtl/mult_div_if.sv
// Handshake and data bundle between the core and the multiply/divide unit.
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 radix-2 steps per operation.
// Operands are reduced to magnitudes on start; signs are re-applied in FIX.
// Build option: define MULDIV_DIV_EN to include the restoring divider.
// Without it DIV/DIVU complete immediately as no-ops (HI/LO untouched).
//
// state | meaning
// IDLE  | waiting for start, MTHI/MTLO writes allowed
// CALC  | 32 iteration cycles, HI/LO held
// FIX   | sign correction and HI/LO write-back
module mult_div_unit (
    input  logic       clk,
    input  logic       rst_n,
    mult_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] prod;     // multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}
    logic [31:0] opb;      // multiplicand or divisor magnitude
    logic        neg_q;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod_neg;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.rs_data[31];
    assign b_neg     = signed_op & bus.rt_data[31];
    assign abs_a     = a_neg ? (~bus.rs_data + 32'd1) : bus.rs_data;
    assign abs_b     = b_neg ? (~bus.rt_data + 32'd1) : bus.rt_data;

    // Shift-add: conditionally add the multiplicand, then shift right keeping the carry.
    assign mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opb} : 33'd0);
    assign mul_next  = {mul_sum, prod[31:1]};
    assign prod_neg  = ~prod + 64'd1;

`ifdef MULDIV_DIV_EN
    logic        is_div;
    logic        neg_r;
    logic        div_zero;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    // Restoring step; with a zero divisor the dividend simply shifts into the
    // remainder, which is why HI ends up as rs_data once the sign is restored.
    assign div_shift = {prod[63:32], prod[31]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[32] ? {div_shift[31:0], prod[30:0], 1'b0}
                                    : {div_diff[31:0],  prod[30:0], 1'b1};
    assign rem_fix   = neg_r ? (~prod[63:32] + 32'd1) : prod[63:32];
    assign quo_fix   = div_zero ? 32'hFFFF_FFFF
                     : (neg_q ? (~prod[31:0] + 32'd1) : prod[31:0]);
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Control FSM with registered busy/done and the iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            prod     <= 64'd0;
            opb      <= 32'd0;
            neg_q    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef MULDIV_DIV_EN
                        state    <= CALC;
                        busy_r   <= 1'b1;
                        cnt      <= 5'd0;
                        prod     <= {32'd0, abs_a};
                        opb      <= abs_b;
                        neg_q    <= a_neg ^ b_neg;
                        is_div   <= bus.op[1];
                        neg_r    <= a_neg;
                        div_zero <= (bus.rt_data == 32'd0);
`else
                        if (!bus.op[1]) begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                            cnt    <= 5'd0;
                            prod   <= {32'd0, abs_a};
                            opb    <= abs_b;
                            neg_q  <= a_neg ^ b_neg;
                        end else begin
                            done_r <= 1'b1;
                        end
`endif
                    end else begin
                        if (bus.hi_we) hi_r <= bus.rs_data;
                        if (bus.lo_we) lo_r <= bus.rs_data;
                    end
                end
                CALC: begin
`ifdef MULDIV_DIV_EN
                    prod <= is_div ? div_next : mul_next;
`else
                    prod <= mul_next;
`endif
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    cnt    <= 5'd0;
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        {hi_r, lo_r} <= neg_q ? prod_neg : prod;
                    end
`else
                    {hi_r, lo_r} <= neg_q ? prod_neg : prod;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; expectations adapt to MULDIV_DIV_EN.
module tb_mult_div_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mult_div_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_h, input logic [31:0] exp_l,
                       input int exp_busy, input string tag);
        int n;
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        tick;
        bus.start   = 1'b0;
        if (exp_busy > 0) chk(64'(bus.done), 64'd0, {tag, "_done_early"});
        wait_idle(n);
        chk(64'(n), 64'(exp_busy), {tag, "_busy_cycles"});
        chk(64'(bus.done), 64'd1, {tag, "_done"});
        chk(64'(bus.hi), 64'(exp_h), {tag, "_hi"});
        chk(64'(bus.lo), 64'(exp_l), {tag, "_lo"});
    endtask

    initial begin
        int n;
        bit done_seen;
        errors = 0;
        checks = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        #1;
        chk(64'(bus.busy), 64'd0, "rst_busy");
        chk(64'(bus.done), 64'd0, "rst_done");
        chk(64'(bus.hi), 64'd0, "rst_hi");
        chk(64'(bus.lo), 64'd0, "rst_lo");
        tick;
        tick;
        rst_n = 1'b1;

        // first start on the first edge after reset release
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max");
        tick;
        chk(64'(bus.done), 64'd0, "multu_max_done_width");
        run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult_m3_7");
        // back-to-back start in the done cycle
        run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, "mult_minsq");
        run(2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33, "multu_shift");

        run(2'b10, 32'hFFFF_FFF9, 32'd2,
            DIV_ON ? 32'hFFFF_FFFF : 32'h0000_0001, DIV_ON ? 32'hFFFF_FFFD : 32'h2345_6780,
            DIV_ON ? 33 : 0, "div_m7_2");
        run(2'b11, 32'd100, 32'd0,
            DIV_ON ? 32'd100 : 32'h0000_0001, DIV_ON ? 32'hFFFF_FFFF : 32'h2345_6780,
            DIV_ON ? 33 : 0, "divu_by0");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
            DIV_ON ? 32'd0 : 32'h0000_0001, DIV_ON ? 32'h8000_0000 : 32'h2345_6780,
            DIV_ON ? 33 : 0, "div_ovf");
        run(2'b11, 32'd100, 32'd7,
            DIV_ON ? 32'd2 : 32'h0000_0001, DIV_ON ? 32'd14 : 32'h2345_6780,
            DIV_ON ? 33 : 0, "divu_100_7");
        run(2'b10, 32'd7, 32'hFFFF_FFFE,
            DIV_ON ? 32'd1 : 32'h0000_0001, DIV_ON ? 32'hFFFF_FFFD : 32'h2345_6780,
            DIV_ON ? 33 : 0, "div_7_m2");
        run(2'b10, 32'hFFFF_FFF9, 32'd0,
            DIV_ON ? 32'hFFFF_FFF9 : 32'h0000_0001, DIV_ON ? 32'hFFFF_FFFF : 32'h2345_6780,
            DIV_ON ? 33 : 0, "div_neg_by0");
        tick;

        // MTHI / MTLO in IDLE
        bus.hi_we = 1'b1;
        bus.rs_data = 32'hDEAD_BEEF;
        tick;
        bus.hi_we = 1'b0;
        chk(64'(bus.hi), 64'hDEAD_BEEF, "mthi_hi");
        chk(64'(bus.lo), DIV_ON ? 64'hFFFF_FFFF : 64'h2345_6780, "mthi_lo_kept");
        bus.lo_we = 1'b1;
        bus.rs_data = 32'h1234_5678;
        tick;
        bus.lo_we = 1'b0;
        chk(64'(bus.lo), 64'h1234_5678, "mtlo_lo");
        chk(64'(bus.hi), 64'hDEAD_BEEF, "mtlo_hi_kept");

        // start wins over simultaneous MTHI/MTLO
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        tick;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk(64'(bus.hi), 64'hDEAD_BEEF, "startwin_hi");
        chk(64'(bus.lo), 64'h1234_5678, "startwin_lo");
        wait_idle(n);
        chk(64'(n), 64'd33, "startwin_busy_cycles");
        chk(64'(bus.hi), 64'd0, "startwin_res_hi");
        chk(64'(bus.lo), 64'd6, "startwin_res_lo");
        tick;

        // start and MTHI while busy are ignored
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd5; bus.rt_data = 32'd5;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'hCAFE_F00D; bus.rt_data = 32'd3;
        bus.hi_we = 1'b1;
        tick;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        chk(64'(bus.busy), 64'd1, "busy_ign_busy");
        chk(64'(bus.hi), 64'd0, "busy_ign_hold_hi");
        chk(64'(bus.lo), 64'd6, "busy_ign_hold_lo");
        wait_idle(n);
        chk(64'(n), 64'd23, "busy_ign_remaining");
        chk(64'(bus.done), 64'd1, "busy_ign_done");
        chk(64'(bus.hi), 64'd0, "busy_ign_hi");
        chk(64'(bus.lo), 64'd25, "busy_ign_lo");
        tick;
        chk(64'(bus.busy), 64'd0, "busy_ign_no_restart");

        // reset in the middle of an operation
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'd3;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 19; i++) tick;
        rst_n = 1'b0;
        #1;
        chk(64'(bus.busy), 64'd0, "abort_busy");
        chk(64'(bus.hi), 64'd0, "abort_hi");
        chk(64'(bus.lo), 64'd0, "abort_lo");
        done_seen = 1'b0;
        tick;
        done_seen |= bus.done;
        tick;
        done_seen |= bus.done;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            done_seen |= bus.done;
        end
        chk(64'(done_seen), 64'd0, "abort_no_done");
        chk(64'(bus.lo), 64'd0, "abort_lo_after");
        run(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 33, "mult_2_3");
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
